// File: rtl/ping_sequencer.sv
// Autonomous ping scheduler: arm, transmit burst, listen window, sample-buffer peak scan,
// then DAC gain nudge, repeated every `period` cycles while `start` is held.
module ping_sequencer #(
    parameter int                 TX_CYCLES = 40,
    parameter int                 RX_WINDOW = 100,
    parameter int                 DEPTH     = 128,
    parameter int                 ADDR_W    = 7,
    parameter int                 DATA_W    = 25,
    parameter int                 PERIOD_W  = 20,
    parameter logic [DATA_W-1:0]  PEAK_HI   = DATA_W'('h0C0000),
    parameter logic [DATA_W-1:0]  PEAK_LO   = DATA_W'('h040000),
    parameter logic [7:0]         STEP      = 8'h01
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    output logic                valid_o,
    output logic                on_o,
    output logic                off_o,
    output logic                send_en_o,
    output logic                rec_en_o,
    output logic                inc_o,
    output logic                dec_o,
    output logic [7:0]          amount_o,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   read_add,
    input  logic [DATA_W-1:0]   read_data,
    output logic [DATA_W-1:0]   peak,
    output logic [ADDR_W-1:0]   peak_idx,
    output logic                ping_done,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_TX, S_LISTEN, S_SCAN, S_ADJUST, S_WAIT, S_OFF
    } state_t;

    localparam logic [PERIOD_W-1:0] ONE       = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] TX_LAST   = PERIOD_W'(TX_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] RX_LAST   = PERIOD_W'(RX_WINDOW - 1);
    localparam logic [PERIOD_W-1:0] SCAN_LAST = PERIOD_W'(DEPTH);
    localparam logic [PERIOD_W-1:0] SCAN_RD   = PERIOD_W'(DEPTH);
    localparam logic [PERIOD_W-1:0] PING_LEN  = PERIOD_W'(TX_CYCLES + RX_WINDOW + DEPTH + 3);

    // Gain decision on the final peak: {dec, inc}; the two are mutually exclusive by construction.
    function automatic logic [1:0] gain_cmd(input logic [DATA_W-1:0] pk);
        if (pk > PEAK_HI)
            return 2'b10;
        else if (pk < PEAK_LO)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] cnt, cnt_nxt;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] wait_last;
    logic                start_q;

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   max_run;
    logic [ADDR_W-1:0]   max_idx;
    logic [DATA_W-1:0]   max_final;
    logic [ADDR_W-1:0]   idx_final;
    logic                scan_exit;

    logic                valid_n, on_n, off_n, send_n, rec_n, inc_n, dec_n;
    logic                rd_en_n, done_n, busy_n;
    logic [7:0]          amount_n;
    logic [ADDR_W-1:0]   read_add_n;

    assign wait_last = (period_q > PING_LEN) ? (period_q - PING_LEN - ONE) : '0;
    assign scan_exit = (state == S_SCAN) && (state_nxt == S_ADJUST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            period_q <= '0;
            start_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            start_q <= start;
            if (state == S_ARM)
                period_q <= period;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + ONE;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start_q)
                    state_nxt = S_ARM;
            end
            S_ARM: begin
                cnt_nxt   = '0;
                state_nxt = S_TX;
            end
            S_TX: begin
                if (cnt == TX_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_LISTEN;
                end
            end
            S_LISTEN: begin
                if (cnt == RX_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_ADJUST;
                end
            end
            S_ADJUST: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == wait_last) begin
                    cnt_nxt   = '0;
                    state_nxt = start_q ? S_ARM : S_OFF;
                end
            end
            S_OFF: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage p1: sample returned for the address issued one cycle earlier; strict '>' keeps lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= rd_en;
    end

    always_ff @(posedge clk) begin
        addr_p1 <= read_add;
        if (state == S_ARM) begin
            max_run <= '0;
            max_idx <= '0;
        end else begin
            max_run <= max_final;
            max_idx <= idx_final;
        end
    end

    always_comb begin
        max_final = max_run;
        idx_final = max_idx;
        if (vld_p1 && (read_data > max_run)) begin
            max_final = read_data;
            idx_final = addr_p1;
        end
    end

    // Outputs are decoded from the upcoming state so every command register flips exactly at a state boundary.
    always_comb begin
        valid_n    = 1'b0;
        on_n       = 1'b0;
        off_n      = 1'b0;
        send_n     = 1'b0;
        rec_n      = 1'b0;
        inc_n      = 1'b0;
        dec_n      = 1'b0;
        rd_en_n    = 1'b0;
        done_n     = 1'b0;
        amount_n   = '0;
        read_add_n = '0;
        case (state_nxt)
            S_ARM: begin
                valid_n = 1'b1;
                on_n    = 1'b1;
            end
            S_TX: begin
                valid_n = 1'b1;
                send_n  = 1'b1;
            end
            S_LISTEN: begin
                valid_n = 1'b1;
                rec_n   = 1'b1;
            end
            S_SCAN: begin
                if (cnt_nxt < SCAN_RD) begin
                    rd_en_n    = 1'b1;
                    read_add_n = cnt_nxt[ADDR_W-1:0];
                end
            end
            S_ADJUST: begin
                valid_n        = 1'b1;
                done_n         = 1'b1;
                {dec_n, inc_n} = gain_cmd(max_final);
                if (dec_n || inc_n)
                    amount_n = STEP;
            end
            S_OFF: off_n = 1'b1;
            default: ;
        endcase
        busy_n = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o   <= 1'b0;
            on_o      <= 1'b0;
            off_o     <= 1'b0;
            send_en_o <= 1'b0;
            rec_en_o  <= 1'b0;
            inc_o     <= 1'b0;
            dec_o     <= 1'b0;
            amount_o  <= '0;
            rd_en     <= 1'b0;
            read_add  <= '0;
            ping_done <= 1'b0;
            busy      <= 1'b0;
            peak      <= '0;
            peak_idx  <= '0;
        end else begin
            valid_o   <= valid_n;
            on_o      <= on_n;
            off_o     <= off_n;
            send_en_o <= send_n;
            rec_en_o  <= rec_n;
            inc_o     <= inc_n;
            dec_o     <= dec_n;
            amount_o  <= amount_n;
            rd_en     <= rd_en_n;
            read_add  <= read_add_n;
            ping_done <= done_n;
            busy      <= busy_n;
            if (scan_exit) begin
                peak     <= max_final;
                peak_idx <= idx_final;
            end
        end
    end

endmodule
